idx_vec_builder: RTL

IDX_VEC_BUILDER -- requirements
Module: idx_vec_builder

---
 rtl/idx_vec_builder.sv | 97 +++++++++
 1 files changed

// File: rtl/idx_vec_builder.sv
// rtl/idx_vec_builder.sv - rebuilds a bit vector from a frame of zero-count indices
// Beats set bits in a frame accumulator; the last beat hands the frame to a one-deep output register.
module idx_vec_builder #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    parameter int unsigned POP_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [CNT_WIDTH-1:0] cnt_i,
    input  logic                 empty_i,
    input  logic                 last_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [WIDTH-1:0]     vec_o,
    output logic [POP_WIDTH-1:0] pop_o,
    output logic                 dup_o,
    output logic                 oor_o
);

    logic [WIDTH-1:0]     acc_q, acc_d, hit;
    logic [POP_WIDTH-1:0] pop_q, pop_d;
    logic                 dup_q, dup_d, oor_q, oor_d;
    logic [CNT_WIDTH-1:0] tgt;
    logic                 accept, contrib, in_range, already, close;

    // Depends only on registered valid_o and downstream ready, never on valid_i.
    assign ready_o = !valid_o || ready_i;

    always_comb begin
        accept   = valid_i && ready_o;
        contrib  = accept && !empty_i;
        close    = accept && last_i;
        in_range = 32'(cnt_i) < WIDTH;
        tgt      = MODE ? CNT_WIDTH'(WIDTH - 1 - 32'(cnt_i)) : cnt_i;
        hit      = in_range ? (WIDTH'(1) << tgt) : '0;
        already  = |(acc_q & hit);

        acc_d = acc_q;
        pop_d = pop_q;
        dup_d = dup_q;
        oor_d = oor_q;
        if (contrib) begin
            acc_d = acc_q | hit;
            if (!in_range) begin
                oor_d = 1'b1;
            end else if (already) begin
                dup_d = 1'b1;
            end else if (pop_q != POP_WIDTH'(WIDTH)) begin
                pop_d = pop_q + POP_WIDTH'(1);
            end
        end
    end

    // Frame accumulator: the last beat's own contribution goes out, then it starts clean.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            pop_q <= '0;
            dup_q <= 1'b0;
            oor_q <= 1'b0;
        end else if (close) begin
            acc_q <= '0;
            pop_q <= '0;
            dup_q <= 1'b0;
            oor_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            pop_q <= pop_d;
            dup_q <= dup_d;
            oor_q <= oor_d;
        end
    end

    // Output register reloads on a last beat even while draining, so back-to-back frames have no bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            vec_o   <= '0;
            pop_o   <= '0;
            dup_o   <= 1'b0;
            oor_o   <= 1'b0;
        end else if (close) begin
            valid_o <= 1'b1;
            vec_o   <= acc_d;
            pop_o   <= pop_d;
            dup_o   <= dup_d;
            oor_o   <= oor_d;
        end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule
